// File: rtl/bfly_unit.sv
// Radix-2 complex butterfly X = A + W*B, Y = A - W*B on Q1.(N-1) operands; SATURATE_EN clamps overflow instead of wrapping.
// Latency 3 cycles, throughput 1 per cycle; sticky ovf flag with synchronous clear (set wins).
// Backpressure: a stage loads when empty or when its successor loads; in_ready drops only with all stages full.
module bfly_unit #(
    parameter int N      = 8,
    parameter int STAGES = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a_re,
    input  logic [N-1:0] a_im,
    input  logic [N-1:0] b_re,
    input  logic [N-1:0] b_im,
    input  logic [N-1:0] w_re,
    input  logic [N-1:0] w_im,
    input  logic         scale,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] x_re,
    output logic [N-1:0] x_im,
    output logic [N-1:0] y_re,
    output logic [N-1:0] y_im,
    output logic         ovf,
    input  logic         ovf_clr
);

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] ld;

    // Stage 1 state: partial products plus carried A and scale
    logic signed [2*N-1:0] m_rr_q, m_ii_q, m_ri_q, m_ir_q;
    logic signed [2*N-1:0] m_rr_d, m_ii_d, m_ri_d, m_ir_d;
    logic        [N-1:0]   s1_are_q, s1_aim_q;
    logic                  s1_scale_q;

    // Stage 2 state: rescaled product P
    logic signed [N+1:0]   p_re_q, p_im_q;
    logic signed [N+1:0]   p_re_d, p_im_d;
    logic        [N-1:0]   s2_are_q, s2_aim_q;
    logic                  s2_scale_q;

    // Stage 3 state: output registers
    logic [N-1:0] x_re_q, x_im_q, y_re_q, y_im_q;
    logic [N-1:0] x_re_d, x_im_d, y_re_d, y_im_d;
    logic         ovf_q;
    logic         ovf_evt;

    always_comb begin
        ld[2] = !vld_q[2] | out_ready;
        ld[1] = !vld_q[1] | ld[2];
        ld[0] = !vld_q[0] | ld[1];
    end

    assign in_ready = ld[0];

    always_comb begin
        logic signed [2*N-1:0] wr_x, wi_x, br_x, bi_x;
        wr_x   = {{N{w_re[N-1]}}, w_re};
        wi_x   = {{N{w_im[N-1]}}, w_im};
        br_x   = {{N{b_re[N-1]}}, b_re};
        bi_x   = {{N{b_im[N-1]}}, b_im};
        m_rr_d = wr_x * br_x;
        m_ii_d = wi_x * bi_x;
        m_ri_d = wr_x * bi_x;
        m_ir_d = wi_x * br_x;
    end

    // Full 2N+1-bit sums, then arithmetic shift by N-1 keeps N+2 bits (truncation toward -inf)
    always_comb begin
        logic signed [2*N:0] pr_full, pi_full;
        pr_full = {m_rr_q[2*N-1], m_rr_q} - {m_ii_q[2*N-1], m_ii_q};
        pi_full = {m_ri_q[2*N-1], m_ri_q} + {m_ir_q[2*N-1], m_ir_q};
        p_re_d  = (N+2)'(pr_full >>> (N-1));
        p_im_d  = (N+2)'(pi_full >>> (N-1));
    end

    // Reduce an N+2-bit value to N bits; bit N of the result flags out-of-range
    function automatic logic [N:0] fit(input logic signed [N+1:0] v);
        logic oor;
        logic [N-1:0] r;
        oor = !((v[N+1:N-1] == 3'b000) || (v[N+1:N-1] == 3'b111));
`ifdef SATURATE_EN
        if (oor)
            r = v[N+1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        else
            r = v[N-1:0];
`else
        r = v[N-1:0];
`endif
        return {oor, r};
    endfunction

    always_comb begin
        logic signed [N+1:0] a_re_x, a_im_x, sx_re, sx_im, sy_re, sy_im;
        logic [N:0] fxr, fxi, fyr, fyi;
        a_re_x = {{2{s2_are_q[N-1]}}, s2_are_q};
        a_im_x = {{2{s2_aim_q[N-1]}}, s2_aim_q};
        sx_re  = a_re_x + p_re_q;
        sx_im  = a_im_x + p_im_q;
        sy_re  = a_re_x - p_re_q;
        sy_im  = a_im_x - p_im_q;
        if (s2_scale_q) begin
            sx_re = sx_re >>> 1;
            sx_im = sx_im >>> 1;
            sy_re = sy_re >>> 1;
            sy_im = sy_im >>> 1;
        end
        fxr     = fit(sx_re);
        fxi     = fit(sx_im);
        fyr     = fit(sy_re);
        fyi     = fit(sy_im);
        x_re_d  = fxr[N-1:0];
        x_im_d  = fxi[N-1:0];
        y_re_d  = fyr[N-1:0];
        y_im_d  = fyi[N-1:0];
        ovf_evt = fxr[N] | fxi[N] | fyr[N] | fyi[N];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q      <= '0;
            m_rr_q     <= '0;
            m_ii_q     <= '0;
            m_ri_q     <= '0;
            m_ir_q     <= '0;
            s1_are_q   <= '0;
            s1_aim_q   <= '0;
            s1_scale_q <= 1'b0;
            p_re_q     <= '0;
            p_im_q     <= '0;
            s2_are_q   <= '0;
            s2_aim_q   <= '0;
            s2_scale_q <= 1'b0;
            x_re_q     <= '0;
            x_im_q     <= '0;
            y_re_q     <= '0;
            y_im_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            if (ld[0]) begin
                vld_q[0] <= in_valid;
                if (in_valid) begin
                    m_rr_q     <= m_rr_d;
                    m_ii_q     <= m_ii_d;
                    m_ri_q     <= m_ri_d;
                    m_ir_q     <= m_ir_d;
                    s1_are_q   <= a_re;
                    s1_aim_q   <= a_im;
                    s1_scale_q <= scale;
                end
            end
            if (ld[1]) begin
                vld_q[1] <= vld_q[0];
                if (vld_q[0]) begin
                    p_re_q     <= p_re_d;
                    p_im_q     <= p_im_d;
                    s2_are_q   <= s1_are_q;
                    s2_aim_q   <= s1_aim_q;
                    s2_scale_q <= s1_scale_q;
                end
            end
            if (ld[2]) begin
                vld_q[2] <= vld_q[1];
                if (vld_q[1]) begin
                    x_re_q <= x_re_d;
                    x_im_q <= x_im_d;
                    y_re_q <= y_re_d;
                    y_im_q <= y_im_d;
                end
            end
            if (ld[2] && vld_q[1] && ovf_evt)
                ovf_q <= 1'b1;
            else if (ovf_clr)
                ovf_q <= 1'b0;
        end
    end

    assign out_valid = vld_q[2];
    assign x_re      = x_re_q;
    assign x_im      = x_im_q;
    assign y_re      = y_re_q;
    assign y_im      = y_im_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/bfly_unit.md
Name: bfly_unit

Overview:
- Parametrised, pipelined radix-2 complex butterfly execution unit; next generation of the FFT datapath, replacing the single scalar signed multiplier.
- Computes X = A + W·B and Y = A − W·B on signed fixed-point complex operands.
- Valid/ready streaming interface with backpressure, selectable per-operation scaling and a sticky overflow flag.
- Sits beside the ALU; fed by the register file or a future sequencer.

Parameters:
- N, 8: component width (bits) of every real/imag operand and result; all values are Q1.(N-1) two's complement.
- STAGES, 3: pipeline depth; fixed at 3 in this revision, exported for benches.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand set presented.
- in_ready  out  1  unit accepts operand set this cycle.
- a_re, a_im, b_re, b_im, w_re, w_im  in  N each  operands A, B, twiddle W.
- scale  in  1  1 = divide both results by 2 (block-floating stage).
- out_valid  out  1  result pair presented.
- out_ready  in  1  consumer accepts result this cycle.
- x_re, x_im, y_re, y_im  out  N each  results X, Y.
- ovf  out  1  sticky overflow flag.
- ovf_clr  in  1  synchronous clear of ovf.

Behaviour:
- Reset (async assert): all stage valid bits = 0, out_valid = 0, ovf = 0, result registers = 0. in_ready = 1 once reset is released.
- Reset asserted mid-operation flushes all in-flight data; nothing is emitted afterwards.
- Transfer occurs on a rising edge with valid & ready high.
- Stage 1: register wr·br, wi·bi, wr·bi, wi·br (2N bits each); carry A and scale.
- Stage 2: pr = wr·br − wi·bi, pi = wr·bi + wi·br (2N+1 bits). Arithmetic shift right by N−1 (truncate toward −inf) to N+2 bits.
- Stage 3: X = A + P, Y = A − P in N+2 bits. If scale = 1, arithmetic shift right 1 (truncate). Reduce to N bits and register to the outputs.
- Latency: 3 cycles from accept to out_valid with out_ready held high. Throughput: 1 per cycle.
- Stall rule: a stage advances when it is empty or the next stage advances. in_ready = !s1_valid | s1_advance; combinational from out_ready, no bubble insertion.
- With out_ready = 0 the unit holds up to 3 results. in_ready drops only when all stages are full. Outputs stay stable while out_valid & !out_ready.
- Order is preserved, with no loss or duplication.
- Overflow: for any of the 4 components, if the N+2-bit (post-scale) value is outside [−2^(N−1), 2^(N−1)−1], the result wraps (low N bits) and ovf sets. ovf is set on the cycle the result is registered into stage 3.
- ovf_clr clears ovf next edge. If ovf_clr coincides with a new overflow event, set wins.
- W = −1 (0x80…) is legal; W = +1 is not representable.

Optional Feature:
- SATURATE_EN defined: out-of-range components clamp to 2^(N−1)−1 or −2^(N−1) instead of wrapping; ovf still sets.
- Undefined: wrap as above. No other behaviour differs.

Test Plan (N = 8):
- A=(10,20), B=(40,−8), W=(64,0), scale=0, out_ready=1 → 3 cycles later X=(30,16), Y=(−10,24), ovf=0.
- Same A, B, W=(0,64) → P=(4,20); X=(14,40), Y=(6,0).
- A=(100,0), B=(127,0), W=(127,0), scale=0 → P=(126,0); X_re=−30 (wrap), Y_re=−26, ovf=1. With SATURATE_EN: X_re=127, ovf=1.
- Same operands with scale=1 → X_re=113, Y_re=−13, ovf stays at its prior value (clear it first → remains 0).
- Push 4 back-to-back sets with out_ready=0 for 6 cycles → in_ready drops after 3 accepts. Release out_ready → 4 results in order, none lost; outputs stable during stall.
- ovf=1, then ovf_clr pulse alone → ovf=0. ovf_clr concurrent with overflowing result → ovf stays 1. Assert reset with 2 ops in flight → out_valid=0, no stale output after release.
